gelato_issue_receiver: RTL and testbench
========================================

// Module: gelato_issue_receiver
// PURPOSE
//  Execute-unit end of the issue-instruction channel: consumes instruction+operand tokens posted
//  by the operand collector (valid/inst/src) and acknowledges each one so the producer clears valid.
//  Buffers accepted entries in a DEPTH-entry FIFO; drains them to the execute datapath over
//  a valid/ready handshake. Sits between operand collector and each execute unit (ALU/LSU/TC).
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  STAT_W  32  width of statistics counters (only with GELATO_ISSUE_STATS_EN)
// PORTS
//  clk           in   1                    clock, all state on rising edge
//  rst_n         in   1                    async active-low reset
//  flush         in   1                    sync flush of buffered entries
//  issue_valid   in   1                    token posted by operand collector
//  issue_inst    in   inst_t               instruction of posted token
//  issue_src     in   warp_reg_t[`RS_INDEX] source operands of posted token
//  issue_ack     out  1                    1-cycle pulse: token captured, producer clears valid
//  exec_valid    out  1                    head entry available
//  exec_ready    in   1                    execute unit takes head entry
//  exec_inst     out  inst_t               head instruction
//  exec_src      out  warp_reg_t[`RS_INDEX] head operands
//  count         out  $clog2(DEPTH)+1      occupancy, 0..DEPTH
//  stat_accepted out  STAT_W               tokens accepted (macro only)
//  stat_stall    out  STAT_W               cycles token blocked by full FIFO (macro only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr/rd pointers=0, count=0, issue_ack=0, exec_valid=0, stats=0.
//    Storage array not reset; exec_inst/exec_src don't-care while exec_valid=0.
//  - Accept condition acc = issue_valid & ~issue_ack & ~flush & (count<DEPTH | pop).
//    On acc: inst/src written at wr_ptr at edge; issue_ack=1 for next cycle only.
//  - issue_ack high cycle never accepts (valid still high then); producer must drop valid on
//    the edge that ends the ack cycle. Peak accept rate: 1 token / 2 cycles.
//  - issue_valid held while blocked; no ack issued until space exists. inst/src must be stable
//    while issue_valid=1 (producer rule; receiver samples on accept edge only).
//  - pop = exec_valid & exec_ready; head advances at edge. exec_valid = (count!=0), exec_* read
//    combinationally from rd_ptr (first-word-fall-through). Accepted entry visible at exec_*
//    the cycle after accept (latency 1, no bypass).
//  - Full (count==DEPTH) with simultaneous pop: accept allowed, count unchanged.
//  - Empty: pop impossible (exec_valid=0); exec_ready ignored.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//  - Pointers PTR_W=$clog2(DEPTH) bits, wrap modulo DEPTH naturally; count separate register.
//  - flush: at edge pointers=0, count=0; no accept, no pop that cycle; issue_ack already high
//    still completes its pulse (token it acknowledges is discarded). Next cycle normal.
//  - Async reset mid-transfer: ack pulse cancelled; producer's pending token lost (system reset).
// CONFIGURATION
//  GELATO_ISSUE_STATS_EN defined: stat_accepted +1 per acc; stat_stall +1 per cycle with
//    issue_valid & ~issue_ack & ~flush & ~acc. Both wrap at 2^STAT_W; cleared by rst_n only.
//  Not defined: stat_* ports and counters absent; no other behaviour change.
// TESTING
//  T1 reset: rst_n=0 mid-run -> issue_ack=0, exec_valid=0, count=0 immediately.
//  T2 single token inst=A, exec_ready=1 -> ack at cycle 1, exec_valid+exec_inst=A at cycle 1,
//     popped; count 1->0 by cycle 2.
//  T3 DEPTH=4, exec_ready=0, 5 tokens back-to-back -> 4 acks at 2-cycle spacing, count=4,
//     5th valid held, no ack; stat_stall increments each blocked cycle (macro on).
//  T4 full + exec_ready=1 for 1 cycle with 5th valid -> 5th accepted same edge as pop, count=4,
//     order out A,B,C,D,E preserved.
//  T5 count=3, flush=1 while issue_valid=1 -> count=0, exec_valid=0 next cycle, no ack that cycle;
//     ack following cycle.
//  T6 20 random tokens, random exec_ready -> output order == input order, stat_accepted=20.

Source files
------------

// File: rtl/gelato_issue_receiver.sv
// gelato_issue_receiver: execute-unit end of the issue-instruction channel.
//   Captures instruction+operand tokens posted by the operand collector, acknowledges
//   each with a one-cycle issue_ack pulse, buffers them in a DEPTH-entry FIFO and
//   presents the head entry first-word-fall-through on a valid/ready handshake.
// Ports:
//   clk, rst_n (async, active low), flush (sync discard of buffered entries)
//   issue_valid/issue_inst/issue_src in, issue_ack out        : producer side
//   exec_valid/exec_inst/exec_src out, exec_ready in          : execute side
//   count out                                                 : occupancy 0..DEPTH
//   stat_accepted/stat_stall out                              : only with GELATO_ISSUE_STATS_EN
// Optional feature macro: GELATO_ISSUE_STATS_EN (statistics counters and their ports).

`ifndef RS_INDEX
`define RS_INDEX 3
`endif

package gelato_issue_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = 2;
    localparam int unsigned NSRC  = `RS_INDEX;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [3:0]  warp_id;
        logic [15:0] imm;
    } inst_t;

    typedef logic [LANES*XLEN-1:0] warp_reg_t;
    typedef warp_reg_t [NSRC-1:0]  src_t;

    typedef struct packed {
        inst_t inst;
        src_t  src;
    } entry_t;
endpackage

module gelato_issue_receiver
    import gelato_issue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4     // power of two, >= 2
`ifdef GELATO_ISSUE_STATS_EN
    ,
    parameter int unsigned STAT_W = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  inst_t                   issue_inst,
    input  src_t                    issue_src,
    output logic                    issue_ack,
    output logic                    exec_valid,
    input  logic                    exec_ready,
    output inst_t                   exec_inst,
    output src_t                    exec_src,
    output logic [$clog2(DEPTH):0]  count
`ifdef GELATO_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0]       stat_accepted,
    output logic [STAT_W-1:0]       stat_stall
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage is deliberately not reset; head contents are don't-care while empty.
    entry_t             mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               issue_ack_q, issue_ack_d;
    logic               exec_valid_q, exec_valid_d;
    logic               pop, acc, full;
    entry_t             wr_entry;
    entry_t             head;

`ifdef GELATO_ISSUE_STATS_EN
    logic [STAT_W-1:0]  stat_acc_q, stat_acc_d;
    logic [STAT_W-1:0]  stat_stall_q, stat_stall_d;
`endif

    // Next-state: accept/pop decision, pointer and occupancy update.
    always_comb begin
        full         = (count_q == DEPTH_C);
        pop          = exec_valid_q & exec_ready & ~flush;
        // The ack cycle never accepts: valid is still the token just captured.
        acc          = issue_valid & ~issue_ack_q & ~flush & (~full | pop);
        wr_entry     = '{inst: issue_inst, src: issue_src};
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(acc) - CNT_W'(pop);
        end
        issue_ack_d  = acc;
        exec_valid_d = (count_d != '0);
`ifdef GELATO_ISSUE_STATS_EN
        stat_acc_d   = stat_acc_q + STAT_W'(acc);
        stat_stall_d = stat_stall_q
                     + STAT_W'(issue_valid & ~issue_ack_q & ~flush & ~acc);
`endif
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            issue_ack_q  <= 1'b0;
            exec_valid_q <= 1'b0;
`ifdef GELATO_ISSUE_STATS_EN
            stat_acc_q   <= '0;
            stat_stall_q <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            issue_ack_q  <= issue_ack_d;
            exec_valid_q <= exec_valid_d;
`ifdef GELATO_ISSUE_STATS_EN
            stat_acc_q   <= stat_acc_d;
            stat_stall_q <= stat_stall_d;
`endif
        end
    end

    // Token storage, written only on the accept edge.
    always_ff @(posedge clk) begin
        if (acc) mem_q[wr_ptr_q] <= wr_entry;
    end

    // First-word-fall-through head read.
    always_comb begin
        head = mem_q[rd_ptr_q];
    end

    assign issue_ack  = issue_ack_q;
    assign exec_valid = exec_valid_q;
    assign exec_inst  = head.inst;
    assign exec_src   = head.src;
    assign count      = count_q;
`ifdef GELATO_ISSUE_STATS_EN
    assign stat_accepted = stat_acc_q;
    assign stat_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_gelato_issue_receiver.sv
// Testbench for gelato_issue_receiver: directed steps plus a randomized stream,
// with a cycle model and an in-order scoreboard of accepted tokens.
`timescale 1ns/1ps
module tb_gelato_issue_receiver;
    import gelato_issue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    inst_t       issue_inst = '0;
    src_t        issue_src = '0;
    logic        issue_ack;
    logic        exec_valid;
    logic        exec_ready = 1'b0;
    inst_t       exec_inst;
    src_t        exec_src;
    logic [2:0]  count;
`ifdef GELATO_ISSUE_STATS_EN
    logic [31:0] stat_accepted;
    logic [31:0] stat_stall;
`endif

    gelato_issue_receiver #(
        .DEPTH(DEPTH)
`ifdef GELATO_ISSUE_STATS_EN
        , .STAT_W(32)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_src(issue_src),
        .issue_ack(issue_ack),
        .exec_valid(exec_valid), .exec_ready(exec_ready),
        .exec_inst(exec_inst), .exec_src(exec_src),
        .count(count)
`ifdef GELATO_ISSUE_STATS_EN
        , .stat_accepted(stat_accepted), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    entry_t      pend[$];     // producer tokens not yet accepted
    entry_t      exp_q[$];    // scoreboard: accepted, not yet popped
    int unsigned m_count = 0;
    bit          m_ack = 1'b0;
    int unsigned m_sacc = 0;
    int unsigned m_sstall = 0;
    int unsigned n_out = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk_tok(input int unsigned tag);
        entry_t e;
        e.inst.opcode  = 7'(tag);
        e.inst.rd      = 5'($urandom);
        e.inst.warp_id = 4'($urandom);
        e.inst.imm     = 16'($urandom);
        for (int i = 0; i < NSRC; i++) e.src[i] = {$urandom, $urandom};
        return e;
    endfunction

    // Present the oldest pending token (inputs change at negedge only).
    task automatic drive();
        issue_valid = (pend.size() != 0);
        if (pend.size() != 0) begin
            issue_inst = pend[0].inst;
            issue_src  = pend[0].src;
        end
    endtask

    // Check outputs against the model mid-cycle, then advance one clock.
    task automatic tick();
        bit pop, acc, stall;
        chk("issue_ack", issue_ack, m_ack);
        chk("count", count, m_count);
        chk("exec_valid", exec_valid, m_count != 0);
        if (m_count != 0) chk("exec_entry", {exec_inst, exec_src}, exp_q[0]);
`ifdef GELATO_ISSUE_STATS_EN
        chk("stat_accepted", stat_accepted, m_sacc);
        chk("stat_stall", stat_stall, m_sstall);
`endif
        pop   = (m_count != 0) && exec_ready && !flush;
        acc   = issue_valid && !m_ack && !flush && (m_count < DEPTH || pop);
        stall = issue_valid && !m_ack && !flush && !acc;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                m_count--;
                n_out++;
            end
            if (acc) begin
                exp_q.push_back('{inst: issue_inst, src: issue_src});
                m_count++;
                void'(pend.pop_front());
            end
        end
        m_ack     = acc;
        m_sacc   += 32'(acc);
        m_sstall += 32'(stall);
        @(negedge clk);
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        entry_t a;
        bit     done;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", issue_ack, 1'b0);
        chk("rst_valid", exec_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: single token with exec_ready=1
        a = mk_tok(1);
        pend.push_back(a);
        exec_ready = 1'b1;
        drive();
        tick();
        chk("t2_ack", issue_ack, 1'b1);
        chk("t2_valid", exec_valid, 1'b1);
        chk("t2_inst", exec_inst, a.inst);
        tick();
        chk("t2_count_empty", count, 3'd0);
        chk("t2_valid_low", exec_valid, 1'b0);
        tick();

        // T3: five tokens into a stalled consumer
        exec_ready = 1'b0;
        for (int i = 0; i < 5; i++) pend.push_back(mk_tok(16 + i));
        drive();
        repeat (12) tick();
        chk("t3_count_full", count, 3'd4);
        chk("t3_no_ack", issue_ack, 1'b0);
        chk("t3_pending", pend.size(), 1);
`ifdef GELATO_ISSUE_STATS_EN
        chk("t3_stalls", stat_stall, 32'd4);
`endif

        // T4: one pop while full lets the 5th token in on the same edge
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        chk("t4_count", count, 3'd4);
        chk("t4_ack", issue_ack, 1'b1);
        tick();
        exec_ready = 1'b1;
        repeat (6) tick();
        chk("t4_drained", count, 3'd0);

        // T5: flush at count=3 while a token is posted
        exec_ready = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(mk_tok(32 + i));
        drive();
        repeat (6) tick();
        chk("t5_count3", count, 3'd3);
        pend.push_back(mk_tok(40));
        drive();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_count0", count, 3'd0);
        chk("t5_valid0", exec_valid, 1'b0);
        chk("t5_no_ack", issue_ack, 1'b0);
        tick();
        chk("t5_ack_after", issue_ack, 1'b1);
        exec_ready = 1'b1;
        repeat (3) tick();

        // T1: async reset during an ack pulse
        exec_ready = 1'b0;
        pend.push_back(mk_tok(48));
        pend.push_back(mk_tok(49));
        drive();
        tick();
        chk("t1_pre_ack", issue_ack, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_ack", issue_ack, 1'b0);
        chk("t1_valid", exec_valid, 1'b0);
        chk("t1_count", count, 3'd0);
        pend.delete();
        exp_q.delete();
        m_count = 0; m_ack = 1'b0; m_sacc = 0; m_sstall = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T6: 20 random tokens against a random consumer
        n_out = 0;
        for (int i = 0; i < 20; i++) pend.push_back(mk_tok(64 + i));
        drive();
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            exec_ready = 1'($urandom_range(0, 1));
            tick();
            done = (pend.size() == 0) && (m_count == 0) && !m_ack;
        end
        chk("t6_drain_in_budget", done, 1'b1);
        chk("t6_out_count", n_out, 20);
`ifdef GELATO_ISSUE_STATS_EN
        chk("t6_stat_accepted", stat_accepted, 32'd20);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
